// File: rtl/month_counter.sv
// month_counter: month stage of the calendar chain.
//   Counts 1..12, advanced by the day counter's carry (run mode) or by the up_n key
//   (set mode). Reports days-in-month to the day counter (leap-aware from year_count),
//   drives two active-low 7-segment digits and pulses year_carry on Dec->Jan in run mode.
//   Optional feature macro: MONTH_AUTOREPEAT_EN (key auto-repeat while up_n is held).
module month_counter #(
  parameter logic [3:0] RESET_MONTH   = 4'd1,
  parameter int         SYNC_STAGES   = 2,
  parameter int         REPEAT_CYCLES = 25000000
) (
  input  logic        clock_in0,
  input  logic        reset,
  input  logic        day_carry,
  input  logic        up_n,
  input  logic        set,
  input  logic [13:0] year_count,
  output logic [3:0]  month_count,
  output logic [13:0] month_7seg,
  output logic [4:0]  days_in_month,
  output logic        year_carry
);

  // Active-low gfedcba pattern for one decimal digit.
  function automatic logic [6:0] seg_digit(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Both digits of a month: {tens, units}; the tens digit shows 0 for months below 10.
  function automatic logic [13:0] seg_month(input logic [3:0] month);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = (month >= 4'd10) ? 4'd1 : 4'd0;
    units = (month >= 4'd10) ? month - 4'd10 : month;
    return {seg_digit(tens), seg_digit(units)};
  endfunction

  // Gregorian leap rule; year 0 counts as leap (divisible by 400).
  function automatic logic is_leap(input logic [13:0] year);
    return ((year[1:0] == 2'b00) && ((year % 14'd100) != 14'd0)) ||
           ((year % 14'd400) == 14'd0);
  endfunction

  function automatic logic [4:0] month_days(input logic [3:0] month, input logic [13:0] year);
    logic [4:0] days;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
      4'd2:                    days = is_leap(year) ? 5'd29 : 5'd28;
      default:                 days = 5'd31;
    endcase
    return days;
  endfunction

  // Synchronizer chains (MSB is the synchronized value) and edge-detect history.
  logic [SYNC_STAGES-1:0] dc_sync;
  logic [SYNC_STAGES-1:0] up_sync;
  logic [SYNC_STAGES-1:0] set_sync;
  logic                   dc_hist;
  logic                   up_hist;

  logic dc_s;
  logic up_s;
  logic set_mode;
  logic run_evt;
  logic press_evt;
  logic rpt_evt;
  logic advance;

  logic [3:0] month_next;
  logic       wrap;

  // Input synchronizers and history flops; history runs in both modes so a mode
  // switch never manufactures an edge from a level that was already present.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock_in0 or negedge reset) begin
    if (!reset) begin
      dc_sync  <= '0;
      up_sync  <= '1;
      set_sync <= '0;
      dc_hist  <= 1'b0;
      up_hist  <= 1'b1;
    end else begin
      dc_sync  <= {dc_sync[SYNC_STAGES-2:0], day_carry};
      up_sync  <= {up_sync[SYNC_STAGES-2:0], up_n};
      set_sync <= {set_sync[SYNC_STAGES-2:0], set};
      dc_hist  <= dc_sync[SYNC_STAGES-1];
      up_hist  <= up_sync[SYNC_STAGES-1];
    end
  end

  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign up_s      = up_sync[SYNC_STAGES-1];
  assign set_mode  = set_sync[SYNC_STAGES-1];
  assign run_evt   = !set_mode && dc_s && !dc_hist;
  assign press_evt = set_mode && up_hist && !up_s;

`ifdef MONTH_AUTOREPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_CYCLES + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_armed;

  // Hold timer: armed by a press, fires every REPEAT_CYCLES while the key stays down,
  // and is cleared by release or by leaving set mode.
  always_ff @(posedge clock_in0 or negedge reset) begin
    if (!reset) begin
      hold_cnt   <= '0;
      hold_armed <= 1'b0;
    end else if (!set_mode || up_s) begin
      hold_cnt   <= '0;
      hold_armed <= 1'b0;
    end else if (press_evt) begin
      hold_cnt   <= '0;
      hold_armed <= 1'b1;
    end else if (hold_armed) begin
      hold_cnt   <= rpt_evt ? '0 : hold_cnt + 1'b1;
    end
  end

  assign rpt_evt = hold_armed && set_mode && !up_s &&
                   (hold_cnt == HOLD_W'(REPEAT_CYCLES - 1));
`else
  assign rpt_evt = 1'b0;
`endif

  assign advance = run_evt || press_evt || rpt_evt;

  // Next-month selection; a bad month state recovers to January without a carry.
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    month_next = month_count;
    wrap       = 1'b0;
    if (advance) begin
      if (month_count >= 4'd1 && month_count <= 4'd11) begin
        month_next = month_count + 4'd1;
      end else if (month_count == 4'd12) begin
        month_next = 4'd1;
        wrap       = 1'b1;
      end else begin
        month_next = 4'd1;
      end
    end
  end

  // Month register with its display and the run-mode year carry, updated together.
  always_ff @(posedge clock_in0 or negedge reset) begin
    if (!reset) begin
      month_count <= RESET_MONTH;
      month_7seg  <= seg_month(RESET_MONTH);
      year_carry  <= 1'b0;
    end else begin
      month_count <= month_next;
      month_7seg  <= seg_month(month_next);
      year_carry  <= wrap && run_evt;
    end
  end

  // Days-in-month follows month_count/year_count one cycle later.
  always_ff @(posedge clock_in0 or negedge reset) begin
    if (!reset) begin
      days_in_month <= 5'd31;
    end else begin
      days_in_month <= month_days(month_count, year_count);
    end
  end

endmodule

// File: tb/tb_month_counter.sv
// Self-checking bench for month_counter: table-driven run sequence and leap-year
// vectors, scoreboard of expected month updates, plus hand-written corner cases.
module tb_month_counter;

  localparam int SYNC = 2;

  logic        clock_in0;
  logic        reset;
  logic        day_carry;
  logic        up_n;
  logic        set;
  logic [13:0] year_count;
  logic [3:0]  month_count;
  logic [13:0] month_7seg;
  logic [4:0]  days_in_month;
  logic        year_carry;

  month_counter #(
    .RESET_MONTH  (4'd1),
    .SYNC_STAGES  (SYNC),
    .REPEAT_CYCLES(10)
  ) dut (
    .clock_in0    (clock_in0),
    .reset        (reset),
    .day_carry    (day_carry),
    .up_n         (up_n),
    .set          (set),
    .year_count   (year_count),
    .month_count  (month_count),
    .month_7seg   (month_7seg),
    .days_in_month(days_in_month),
    .year_carry   (year_carry)
  );

  initial clock_in0 = 1'b0;
  always #5 clock_in0 = ~clock_in0;

  typedef struct {
    logic [3:0] month;
    logic       carry;
    logic [4:0] days;
  } exp_t;

  typedef struct {
    logic [13:0] year;
    logic [4:0]  days;
  } leap_vec_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   carry_cnt = 0;

  logic [6:0] digit_lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [13:0] seg_ref(input int month);
    return {digit_lut[month / 10], digit_lut[month % 10]};
  endfunction

  function automatic logic [4:0] dim_ref(input int month, input int year);
    bit leap;
    leap = (year % 400 == 0) || ((year % 4 == 0) && (year % 100 != 0));
    if (month == 2) return leap ? 5'd29 : 5'd28;
    if (month == 4 || month == 6 || month == 9 || month == 11) return 5'd30;
    return 5'd31;
  endfunction

  // Count year_carry pulses over the whole run, sampled away from the active edge.
  always @(negedge clock_in0) begin
    if (reset && year_carry) carry_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in0);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one advance (day_carry pulse or key press), push the expectation, then pop
  // and compare when month_count moves; also checks latency and carry width.
  task automatic advance(input bit use_key, input exp_t e, input string tag);
    logic [3:0] prev;
    exp_t       got;
    int         n;
    bit         seen;
    sb_q.push_back(e);
    prev = month_count;
    if (use_key) up_n = 1'b0;
    else         day_carry = 1'b1;
    n = 0;
    seen = 0;
    while (n < 20 && !seen) begin
      tick();
      n++;
      if (month_count !== prev) seen = 1;
    end
    got = sb_q.pop_front();
    check({tag, " latency"}, n, SYNC + 1);
    check({tag, " month"}, month_count, got.month);
    check({tag, " seg"}, month_7seg, seg_ref(int'(got.month)));
    check({tag, " carry"}, year_carry, got.carry);
    tick();
    check({tag, " carry clear"}, year_carry, 1'b0);
    check({tag, " days"}, days_in_month, got.days);
    up_n = 1'b1;
    day_carry = 1'b0;
    wait_ticks(SYNC + 2);
  endtask

  initial begin
    exp_t      run_tbl [12];
    leap_vec_t leap_tbl [5];
    exp_t      e;
    int        changes;
    int        exp_changes;
    logic [3:0] last;

    run_tbl = '{'{4'd2, 1'b0, 5'd28}, '{4'd3, 1'b0, 5'd31}, '{4'd4, 1'b0, 5'd30},
                '{4'd5, 1'b0, 5'd31}, '{4'd6, 1'b0, 5'd30}, '{4'd7, 1'b0, 5'd31},
                '{4'd8, 1'b0, 5'd31}, '{4'd9, 1'b0, 5'd30}, '{4'd10, 1'b0, 5'd31},
                '{4'd11, 1'b0, 5'd30}, '{4'd12, 1'b0, 5'd31}, '{4'd1, 1'b1, 5'd31}};
    leap_tbl = '{'{14'd2024, 5'd29}, '{14'd2023, 5'd28}, '{14'd1900, 5'd28},
                 '{14'd2000, 5'd29}, '{14'd0, 5'd29}};

    // Reset state.
    reset = 1'b0;
    day_carry = 1'b0;
    up_n = 1'b1;
    set = 1'b0;
    year_count = 14'd2023;
    wait_ticks(3);
    check("reset month", month_count, 4'd1);
    check("reset days", days_in_month, 5'd31);
    check("reset seg", month_7seg, seg_ref(1));
    check("reset carry", year_carry, 1'b0);
    reset = 1'b1;
    wait_ticks(SYNC + 2);

    // Run mode: twelve day carries walk the year and wrap with one carry.
    for (int i = 0; i < 12; i++) advance(1'b0, run_tbl[i], $sformatf("run%0d", i));
    check("carry pulse count", carry_cnt, 1);

    // February across leap / non-leap years.
    e = '{4'd2, 1'b0, 5'd28};
    advance(1'b0, e, "to feb");
    for (int i = 0; i < 5; i++) begin
      year_count = leap_tbl[i].year;
      wait_ticks(2);
      check($sformatf("feb days y%0d", leap_tbl[i].year), days_in_month, leap_tbl[i].days);
    end
    year_count = 14'd2023;
    wait_ticks(2);

    // Set mode: key presses advance to December, then wrap without a carry.
    set = 1'b1;
    wait_ticks(SYNC + 2);
    for (int m = 3; m <= 12; m++) begin
      e = '{4'(m), 1'b0, dim_ref(m, 2023)};
      advance(1'b1, e, $sformatf("key m%0d", m));
    end
    e = '{4'd1, 1'b0, 5'd31};
    advance(1'b1, e, "key wrap");
    check("carry count after key wrap", carry_cnt, 1);

    // day_carry ignored in set mode.
    day_carry = 1'b1;
    wait_ticks(8);
    day_carry = 1'b0;
    wait_ticks(4);
    check("set mode ignores day_carry", month_count, 4'd1);

    // Mode toggles with held levels must not create events.
    day_carry = 1'b1;
    wait_ticks(6);
    set = 1'b0;
    wait_ticks(6);
    up_n = 1'b0;
    wait_ticks(6);
    set = 1'b1;
    wait_ticks(6);
    set = 1'b0;
    wait_ticks(6);
    check("toggle no advance", month_count, 4'd1);
    up_n = 1'b1;
    day_carry = 1'b0;
    wait_ticks(6);
    check("toggle release no advance", month_count, 4'd1);

    // Run to July, then reset mid-operation with an edge in flight.
    for (int m = 2; m <= 7; m++) begin
      e = '{4'(m), 1'b0, dim_ref(m, 2023)};
      advance(1'b0, e, $sformatf("pre-reset m%0d", m));
    end
    day_carry = 1'b1;
    tick();
    #2 reset = 1'b0;
    #1;
    check("async reset month", month_count, 4'd1);
    check("async reset carry", year_carry, 1'b0);
    check("async reset seg", month_7seg, seg_ref(1));
    check("async reset days", days_in_month, 5'd31);
    day_carry = 1'b0;
    wait_ticks(2);
    reset = 1'b1;
    wait_ticks(8);
    check("pending edge discarded", month_count, 4'd1);

    // Held key in set mode for 35 cycles.
    set = 1'b1;
    wait_ticks(SYNC + 2);
`ifdef MONTH_AUTOREPEAT_EN
    exp_changes = 4;
`else
    exp_changes = 1;
`endif
    changes = 0;
    last = month_count;
    up_n = 1'b0;
    for (int i = 0; i < 35 + SYNC + 4; i++) begin
      if (i == 35) up_n = 1'b1;
      tick();
      if (month_count !== last) changes++;
      last = month_count;
    end
    check("hold advances", changes, exp_changes);
    check("hold final month", month_count, 4'(1 + exp_changes));
    check("hold no carry", carry_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
